uart_wb_master: RTL and testbench

ASCII-command Wishbone master that sits behind the UART receiver and drives a Wishbone bus. It parses hex read and write commands from the byte stream, performs single classic-cycle Wishbone transfers with a timeout, and returns an ASCII status or read data through a byte handshake to the UART transmitter. Address and data widths are generic, so one block serves every bus width in the design.

---
 rtl/uart_wb_pkg.sv | 57 +++++
 rtl/uart_wb_master_if.sv | 33 +++
 rtl/uart_wb_resp_ser.sv | 80 ++++++++
 rtl/uart_wb_master.sv | 206 ++++++++++++++++++++
 tb/tb_uart_wb_master.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_wb_pkg.sv
// Shared types, ASCII constants and hex helpers for the UART-to-Wishbone master.
package uart_wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_SKIP,
    ST_BUS,
    ST_RESP
  } state_t;

  // What the response serializer has to emit.
  typedef enum logic [1:0] {
    RK_OK,   // write acknowledged: "K\n"
    RK_RD,   // read acknowledged: hex digits then "\n"
    RK_ERR,  // parse or bus error: "E\n"
    RK_TMO   // bus timeout: "T\n"
  } resp_kind_t;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_T  = 8'h54;

  // Returns {valid, nibble}; accepts 0-9, a-f and A-F.
  function automatic logic [4:0] hex2nib(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39) r = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
    return r;
  endfunction

  // Lowercase ASCII hex digit for a nibble.
  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h57 + {4'd0, n});
  endfunction

  // Leading status letter for the non-read responses.
  function automatic logic [7:0] resp_char(input resp_kind_t k);
    logic [7:0] r;
    case (k)
      RK_OK:   r = CH_K;
      RK_ERR:  r = CH_E;
      RK_TMO:  r = CH_T;
      default: r = CH_LF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_wb_master_if.sv
// Byte stream and Wishbone signals of the UART-to-Wishbone master.
interface uart_wb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                wb_cyc_o;
  logic                wb_stb_o;
  logic                wb_we_o;
  logic [ADDR_W-1:0]   wb_adr_o;
  logic [DATA_W-1:0]   wb_dat_o;
  logic [DATA_W/8-1:0] wb_sel_o;
  logic [DATA_W-1:0]   wb_dat_i;
  logic                wb_ack_i;
  logic                wb_err_i;
  logic                rx_drop;

  modport master (
    input  rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack_i, wb_err_i,
    output tx_data, tx_valid, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o,
           wb_dat_o, wb_sel_o, rx_drop
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack_i, wb_err_i,
    input  tx_data, tx_valid, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o,
           wb_dat_o, wb_sel_o, rx_drop
  );
endinterface

// File: rtl/uart_wb_resp_ser.sv
// Response serializer: turns a status kind plus read data into ASCII bytes
// on a valid/ready handshake. Each byte is dropped from tx_valid for one
// cycle after acceptance before the next byte is presented.
module uart_wb_resp_ser
  import uart_wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  resp_kind_t        kind_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              tx_ready_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  output logic              done_o
);

  localparam int NDIG = DATA_W / 4;
  localparam int IW   = $clog2(NDIG + 1);

  logic              busy_q;
  resp_kind_t        kind_q;
  logic [DATA_W-1:0] shf_q;
  logic [IW-1:0]     idx_q;
  logic              tx_valid_q;
  logic [7:0]        tx_data_q;
  logic [7:0]        cur_byte;
  logic [7:0]        first_byte;
  logic              last;

  // Byte at position idx_q; read data is consumed MSB-first from shf_q.
  always_comb begin
    cur_byte = CH_LF;
    if (kind_q == RK_RD) begin
      if (idx_q != IW'(NDIG)) cur_byte = nib2hex(shf_q[DATA_W-1 -: 4]);
    end else if (idx_q == '0) begin
      cur_byte = resp_char(kind_q);
    end
  end

  assign first_byte = (kind_i == RK_RD) ? nib2hex(data_i[DATA_W-1 -: 4]) : resp_char(kind_i);
  assign last       = (kind_q == RK_RD) ? (idx_q == IW'(NDIG)) : (idx_q == IW'(1));

  // Load, handshake and advance through the response bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= 1'b0;
      kind_q     <= RK_OK;
      shf_q      <= '0;
      idx_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else if (load_i) begin
      busy_q     <= 1'b1;
      kind_q     <= kind_i;
      shf_q      <= data_i;
      idx_q      <= '0;
      tx_valid_q <= 1'b1;
      tx_data_q  <= first_byte;
    end else if (tx_valid_q && tx_ready_i) begin
      tx_valid_q <= 1'b0;
      if (last) begin
        busy_q <= 1'b0;
      end else begin
        idx_q <= idx_q + IW'(1);
        shf_q <= shf_q << 4;
      end
    end else if (busy_q && !tx_valid_q) begin
      tx_valid_q <= 1'b1;
      tx_data_q  <= cur_byte;
    end
  end

  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;
  assign done_o     = tx_valid_q && tx_ready_i && last;

endmodule

// File: rtl/uart_wb_master.sv
// ASCII command parser driving single classic Wishbone cycles, with a bus
// timeout and an ASCII status/read-data response.
module uart_wb_master
  import uart_wb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic              clk,
  input logic              rst,
  uart_wb_master_if.master bus
);

  localparam int ADIG = ADDR_W / 4;
  localparam int DDIG = DATA_W / 4;
  localparam int ACW  = $clog2(ADIG + 1);
  localparam int DCW  = $clog2(DDIG + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC);

  state_t            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [ACW-1:0]    acnt_q, acnt_d;
  logic [DCW-1:0]    dcnt_q, dcnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              drop_q, drop_d;

  logic              ser_load;
  resp_kind_t        ser_kind;
  logic [DATA_W-1:0] ser_data;
  logic              ser_done;

  logic [7:0]        rx_byte;
  logic [4:0]        nib_v;
  logic              is_hex, is_eol, is_sp, is_r, is_w;

  // Bit 7 of the received byte carries no meaning.
  assign rx_byte = bus.rx_data & 8'h7F;
  assign nib_v   = hex2nib(rx_byte);
  assign is_hex  = nib_v[4];
  assign is_eol  = (rx_byte == CH_CR) || (rx_byte == CH_LF);
  assign is_sp   = (rx_byte == CH_SP);
  assign is_r    = (rx_byte == CH_R) || (rx_byte == (CH_R | 8'h20));
  assign is_w    = (rx_byte == CH_W) || (rx_byte == (CH_W | 8'h20));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      is_wr_q <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      acnt_q  <= '0;
      dcnt_q  <= '0;
      tmo_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      acnt_q  <= acnt_d;
      dcnt_q  <= dcnt_d;
      tmo_q   <= tmo_d;
      drop_q  <= drop_d;
    end
  end

  // Parser, bus sequencing and response hand-off.
  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    acnt_d   = acnt_q;
    dcnt_d   = dcnt_q;
    tmo_d    = tmo_q;
    drop_d   = drop_q;
    ser_load = 1'b0;
    ser_kind = RK_ERR;
    ser_data = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          if (is_r || is_w) begin
            state_d = ST_ADDR;
            is_wr_d = is_w;
            adr_d   = '0;
            dat_d   = '0;
            acnt_d  = '0;
            dcnt_d  = '0;
          end else if (!(is_eol || is_sp)) begin
            state_d = ST_SKIP;
          end
        end
      end

      ST_ADDR: begin
        if (bus.rx_valid) begin
          if (is_hex) begin
            if (acnt_q == ACW'(ADIG)) begin
              state_d = ST_SKIP;
            end else begin
              adr_d  = (adr_q << 4) | ADDR_W'(nib_v[3:0]);
              acnt_d = acnt_q + ACW'(1);
            end
          end else if (is_sp) begin
            state_d = (is_wr_q && acnt_q != '0) ? ST_DATA : ST_SKIP;
          end else if (is_eol) begin
            if (!is_wr_q && acnt_q != '0) begin
              state_d = ST_BUS;
              tmo_d   = '0;
            end else begin
              state_d  = ST_RESP;
              ser_load = 1'b1;
            end
          end else begin
            state_d = ST_SKIP;
          end
        end
      end

      ST_DATA: begin
        if (bus.rx_valid) begin
          if (is_hex) begin
            if (dcnt_q == DCW'(DDIG)) begin
              state_d = ST_SKIP;
            end else begin
              dat_d  = (dat_q << 4) | DATA_W'(nib_v[3:0]);
              dcnt_d = dcnt_q + DCW'(1);
            end
          end else if (is_eol) begin
            if (dcnt_q != '0) begin
              state_d = ST_BUS;
              tmo_d   = '0;
            end else begin
              state_d  = ST_RESP;
              ser_load = 1'b1;
            end
          end else begin
            state_d = ST_SKIP;
          end
        end
      end

      ST_SKIP: begin
        if (bus.rx_valid && is_eol) begin
          state_d  = ST_RESP;
          ser_load = 1'b1;
        end
      end

      ST_BUS: begin
        tmo_d = tmo_q + TW'(1);
        if (bus.rx_valid) drop_d = 1'b1;
        // err outranks ack; a response in the last allowed cycle beats the timeout.
        if (bus.wb_err_i) begin
          state_d  = ST_RESP;
          ser_load = 1'b1;
        end else if (bus.wb_ack_i) begin
          state_d  = ST_RESP;
          ser_load = 1'b1;
          ser_kind = is_wr_q ? RK_OK : RK_RD;
          ser_data = bus.wb_dat_i;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d  = ST_RESP;
          ser_load = 1'b1;
          ser_kind = RK_TMO;
        end
      end

      ST_RESP: begin
        if (bus.rx_valid) drop_d = 1'b1;
        if (ser_done) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  uart_wb_resp_ser #(
    .DATA_W(DATA_W)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load_i    (ser_load),
    .kind_i    (ser_kind),
    .data_i    (ser_data),
    .tx_ready_i(bus.tx_ready),
    .tx_data_o (bus.tx_data),
    .tx_valid_o(bus.tx_valid),
    .done_o    (ser_done)
  );

  assign bus.wb_cyc_o = (state_q == ST_BUS);
  assign bus.wb_stb_o = (state_q == ST_BUS);
  assign bus.wb_we_o  = (state_q == ST_BUS) && is_wr_q;
  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = dat_q;
  assign bus.wb_sel_o = '1;
  assign bus.rx_drop  = drop_q;

endmodule

// File: tb/tb_uart_wb_master.sv
// Self-checking bench for uart_wb_master: directed plan items plus random
// commands, compared against a string-level command model.
module tb_uart_wb_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;

  uart_wb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  uart_wb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Slave behaviour, written only by the main sequence.
  int          sl_mode = 1;  // 0: never answers, 1: ack, 2: err
  int          sl_wait = 0;
  logic [31:0] sl_rd   = '0;

  // Observations, written only by the slave / monitor processes.
  int          cyc_total  = 0;
  int          bus_starts = 0;
  logic [31:0] seen_adr, seen_dat;
  logic [3:0]  seen_sel;
  logic        seen_we, seen_stb;
  logic [7:0]  resp_q[$];
  int          stall_viol = 0;

  // Wishbone slave: answers in the (sl_wait+1)-th cycle of each bus cycle.
  initial begin
    int cur;
    cur = 0;
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_dat_i = '0;
    forever begin
      @(negedge clk);
      if (bus.wb_cyc_o) begin
        cur++;
        cyc_total++;
        if (cur == 1) begin
          bus_starts++;
          seen_adr = bus.wb_adr_o;
          seen_dat = bus.wb_dat_o;
          seen_sel = bus.wb_sel_o;
          seen_we  = bus.wb_we_o;
          seen_stb = bus.wb_stb_o;
        end
        bus.wb_dat_i = sl_rd;
        bus.wb_ack_i = (sl_mode == 1) && (cur == sl_wait + 1);
        bus.wb_err_i = (sl_mode == 2) && (cur == sl_wait + 1);
      end else begin
        cur = 0;
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
      end
    end
  end

  // Transmitter side: random ready, byte capture and hold-stability watch.
  initial begin
    logic       stall_prev;
    logic [7:0] stall_data;
    stall_prev = 1'b0;
    stall_data = 8'h00;
    bus.tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_prev && !rst && !(bus.tx_valid && bus.tx_data == stall_data)) stall_viol++;
      bus.tx_ready = ($urandom_range(0, 3) != 0);
      if (bus.tx_valid && bus.tx_ready && !rst) resp_q.push_back(bus.tx_data);
      stall_prev = bus.tx_valid && !bus.tx_ready;
      stall_data = bus.tx_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed=\"%s\" expected=\"%s\"", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] up(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
  endfunction

  function automatic bit is_hexc(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (up(c) >= 8'h41 && up(c) <= 8'h46);
  endfunction

  function automatic bit valid_hex(input string s);
    bit ok;
    ok = (s.len() >= 1) && (s.len() <= 8);
    for (int i = 0; i < s.len(); i++) if (!is_hexc(s[i])) ok = 0;
    return ok;
  endfunction

  function automatic logic [31:0] hexnum(input string s);
    logic [31:0] v;
    logic [7:0]  c;
    v = '0;
    for (int i = 0; i < s.len(); i++) begin
      c = up(s[i]);
      v = v * 16 + ((c <= 8'h39) ? 32'(c - 8'h30) : 32'(c - 8'h37));
    end
    return v;
  endfunction

  // Reference: what one command line plus slave behaviour should produce.
  function automatic void model(input string cmd, input int mode, input int w, input logic [31:0] rd,
                                output bit bus_exp, output bit we_exp, output logic [31:0] adr_exp,
                                output logic [31:0] dat_exp, output int len_exp, output string resp_exp);
    string      body, apart, dpart;
    logic [7:0] c0, c;
    bit         ok, seen_sp;
    body    = cmd.substr(0, cmd.len() - 2);
    c0      = up(body[0]);
    apart   = "";
    dpart   = "";
    seen_sp = 0;
    for (int i = 1; i < body.len(); i++) begin
      c = body[i];
      if (!seen_sp && c == 8'h20) seen_sp = 1;
      else if (!seen_sp) apart = $sformatf("%s%c", apart, c);
      else dpart = $sformatf("%s%c", dpart, c);
    end
    we_exp = (c0 == 8'h57);
    ok = (c0 == 8'h52 || c0 == 8'h57) && valid_hex(apart);
    if (we_exp) ok = ok && seen_sp && valid_hex(dpart);
    else ok = ok && !seen_sp;
    bus_exp = ok;
    adr_exp = hexnum(apart);
    dat_exp = we_exp ? hexnum(dpart) : 32'h0;
    len_exp = (mode == 0) ? TMO : w + 1;
    if (!ok) resp_exp = "E\n";
    else if (mode == 0) resp_exp = "T\n";
    else if (mode == 2) resp_exp = "E\n";
    else if (we_exp) resp_exp = "K\n";
    else resp_exp = $sformatf("%08h\n", rd);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = {1'($urandom_range(0, 1)), b[6:0]};
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  task automatic wait_cyc(input string tag);
    bit got;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.wb_cyc_o) got = 1;
    end
    check(tag, 64'(got), 64'd1);
  endtask

  task automatic run_cmd(input string name, input string cmd, input int mode, input int w,
                         input logic [31:0] rd, input bit inject);
    int          r0, c0, b0;
    bit          done, bus_exp, we_exp;
    logic [31:0] adr_exp, dat_exp;
    int          len_exp;
    string       resp_exp, got;
    sl_mode = mode;
    sl_wait = w;
    sl_rd   = rd;
    r0 = resp_q.size();
    c0 = cyc_total;
    b0 = bus_starts;
    for (int i = 0; i < cmd.len(); i++) send_byte(cmd[i]);
    if (inject) begin
      wait_cyc({name, "_cyc_up"});
      send_byte(8'h78);
    end
    done = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (resp_q.size() > r0 && resp_q[resp_q.size() - 1] == 8'h0A) done = 1;
    end
    check({name, "_resp_done"}, 64'(done), 64'd1);
    repeat (2) @(negedge clk);
    got = "";
    for (int i = r0; i < resp_q.size(); i++) got = $sformatf("%s%c", got, resp_q[i]);
    model(cmd, mode, w, rd, bus_exp, we_exp, adr_exp, dat_exp, len_exp, resp_exp);
    check_str({name, "_resp"}, got, resp_exp);
    check({name, "_nbus"}, 64'(bus_starts - b0), bus_exp ? 64'd1 : 64'd0);
    if (bus_exp) begin
      check({name, "_adr"}, 64'(seen_adr), 64'(adr_exp));
      check({name, "_we"}, 64'(seen_we), 64'(we_exp));
      check({name, "_cyclen"}, 64'(cyc_total - c0), 64'(len_exp));
      if (we_exp) check({name, "_dat"}, 64'(seen_dat), 64'(dat_exp));
    end
    $display("txn %-10s cmd=%0d bytes mode=%0d wait=%0d resp=%0d bytes", name, cmd.len(), mode, w, got.len());
  endtask

  function automatic string rand_hex(input int n);
    string      digs, s;
    logic [7:0] ch;
    digs = "0123456789abcdef";
    s = "";
    for (int i = 0; i < n; i++) begin
      ch = digs[$urandom_range(0, 15)];
      if ($urandom_range(0, 1) == 1 && ch >= 8'h61) ch = ch - 8'h20;
      s = $sformatf("%s%c", s, ch);
    end
    return s;
  endfunction

  function automatic int rand_ndig();
    int r;
    r = $urandom_range(0, 11);
    return (r == 0) ? 0 : (r == 1) ? 9 : $urandom_range(1, 8);
  endfunction

  initial begin
    string      cmd, body;
    logic [7:0] lead;
    int         pos;
    rst = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
    check("rst_stb", 64'(bus.wb_stb_o), 64'd0);
    check("rst_we", 64'(bus.wb_we_o), 64'd0);
    check("rst_adr", 64'(bus.wb_adr_o), 64'd0);
    check("rst_dat", 64'(bus.wb_dat_o), 64'd0);
    check("rst_txv", 64'(bus.tx_valid), 64'd0);
    check("rst_txd", 64'(bus.tx_data), 64'd0);
    check("rst_drop", 64'(bus.rx_drop), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed plan items.
    run_cmd("wr_wait2", "W1000 deadbeef\r", 1, 2, 32'h0, 0);
    check("wr_sel", 64'(seen_sel), 64'hF);
    check("wr_stb", 64'(seen_stb), 64'd1);
    run_cmd("rd_zero", "r20\n", 1, 0, 32'h0000A5C3, 0);
    run_cmd("rd_tmo", "R44\r", 0, 0, 32'h0, 0);
    run_cmd("bad_hex", "Rxyz\r", 1, 0, 32'h0, 0);
    run_cmd("adr_9dig", "R123456789\r", 1, 0, 32'h0, 0);
    run_cmd("wr_err", "w7 12\n", 2, 1, 32'h0, 0);
    check("drop_before", 64'(bus.rx_drop), 64'd0);

    // A byte arriving during BUS is dropped and flagged.
    run_cmd("drop_bus", "R44\r", 0, 0, 32'h0, 1);
    check("drop_set", 64'(bus.rx_drop), 64'd1);

    // Random commands.
    for (int k = 0; k < 30; k++) begin
      lead = ($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52;
      if ($urandom_range(0, 1) == 1) lead = lead | 8'h20;
      body = $sformatf("%c%s", lead, rand_hex(rand_ndig()));
      if (up(lead) == 8'h57) body = $sformatf("%s %s", body, rand_hex(rand_ndig()));
      if ($urandom_range(0, 7) == 0) begin
        pos = $urandom_range(0, body.len() - 1);
        body[pos] = 8'h67;
      end
      cmd = $sformatf("%s%c", body, ($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
      run_cmd($sformatf("rand%0d", k), cmd, $urandom_range(0, 2), $urandom_range(0, 12), $urandom, 0);
    end
    check("drop_sticky", 64'(bus.rx_drop), 64'd1);
    check("tx_stable", 64'(stall_viol), 64'd0);

    // Reset in the middle of a bus cycle.
    sl_mode = 0;
    send_byte(8'h52);
    send_byte(8'h38);
    send_byte(8'h0D);
    wait_cyc("rst_bus_cyc_up");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstbus_cyc", 64'(bus.wb_cyc_o), 64'd0);
    check("rstbus_stb", 64'(bus.wb_stb_o), 64'd0);
    check("rstbus_txv", 64'(bus.tx_valid), 64'd0);
    check("rstbus_drop", 64'(bus.rx_drop), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_cmd("after_rst", "W0 1\r", 1, 1, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
